// File: rtl/butterfly_pkg.sv
// Shared definitions for the butterfly serial/parallel stages: lane-skew rule and common constants.
package butterfly_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned POPCNT_SPAN        = 8;
    localparam int unsigned CNT_W              = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } p2s_state_e;

    // Lane index = (low counter bits + popcount of the next 8 bits) mod 2**in_bits.
    function automatic logic [7:0] lane_skew(input logic [CNT_W-1:0] cnt,
                                             input int unsigned       in_bits);
        logic [7:0]       hi8;
        logic [7:0]       pc;
        logic [CNT_W-1:0] mask;
        logic [CNT_W-1:0] sum;
        hi8  = 8'(cnt >> in_bits);
        pc   = '0;
        for (int i = 0; i < int'(POPCNT_SPAN); i++) begin
            pc = pc + {7'b0, hi8[i[2:0]]};
        end
        mask = CNT_W'((32'd1 << in_bits) - 32'd1);
        sum  = (cnt & mask) + CNT_W'(pc);
        return 8'(sum & mask);
    endfunction

endpackage

// File: rtl/butterfly_lane_skew.sv
// Combinational counter -> lane index mapping shared by the s2p and p2s stages.
module butterfly_lane_skew
    import butterfly_pkg::*;
#(
    parameter  int unsigned num_input   = 8,
    localparam int unsigned num_in_bits = $clog2(num_input)
) (
    input  logic [CNT_W-1:0]       cnt_i,
    output logic [num_in_bits-1:0] sel_c_o
);

    assign sel_c_o = num_in_bits'(lane_skew(cnt_i, num_in_bits));

endmodule

// File: rtl/butterfly_p2s.sv
// Butterfly parallel-to-serial stage: emits one lane per cycle in skewed order,
// with frame-length truncation and valid/ready on both sides.
module butterfly_p2s
    import butterfly_pkg::*;
#(
    parameter  int unsigned data_width  = DEFAULT_DATA_WIDTH,
    parameter  int unsigned num_input   = 8,
    localparam int unsigned num_in_bits = $clog2(num_input)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [num_input*data_width-1:0]   up_dat,
    input  logic                              up_vld,
    output logic                              up_rdy,
    input  logic [CNT_W-1:0]                  length,
    output logic [data_width-1:0]             dn_dat,
    output logic                              dn_vld,
    input  logic                              dn_rdy
);

    p2s_state_e                      state_q, state_d;
    logic [num_input*data_width-1:0] vec_q;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [CNT_W-1:0]                length_q, length_d;
    logic [num_in_bits-1:0]          ecnt_q, ecnt_d;
    logic [num_in_bits-1:0]          sel_q, sel_d;
    logic [data_width-1:0]           lanes [num_input];
    logic                            full, xfer, vec_end, frame_end, last_elem, accept;

    for (genvar g = 0; g < num_input; g++) begin : g_lane
        assign lanes[g] = vec_q[g*data_width +: data_width];
    end

    assign full      = (state_q == DRAIN);
    assign xfer      = full & dn_rdy;
    assign vec_end   = (ecnt_q == num_in_bits'(num_input - 1));
    assign frame_end = (cnt_q == length_q - CNT_W'(1));
    assign last_elem = xfer & (vec_end | frame_end);
    assign accept    = up_vld & up_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept)              state_d = DRAIN;
            DRAIN: if (last_elem & !accept) state_d = EMPTY;
        endcase
    end

    // Back-to-back vectors: a new one is accepted on the cycle the last lane leaves.
    always_comb begin
        dn_vld = 1'b0;
        up_rdy = 1'b1;
        dn_dat = '0;
        if (full) begin
            dn_vld = 1'b1;
            up_rdy = last_elem;
            dn_dat = lanes[sel_q];
        end
    end

    // Frame length is latched only when the incoming vector begins a frame.
    always_comb begin
        cnt_d    = cnt_q;
        ecnt_d   = ecnt_q;
        length_d = length_q;
        if (xfer) begin
            cnt_d  = frame_end ? '0 : cnt_q + CNT_W'(1);
            ecnt_d = vec_end ? '0 : ecnt_q + num_in_bits'(1);
        end
        if (accept) begin
            ecnt_d = '0;
            if (cnt_d == '0) length_d = length;
        end
    end

    butterfly_lane_skew #(.num_input(num_input)) u_skew (
        .cnt_i   (cnt_d),
        .sel_c_o (sel_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            cnt_q    <= '0;
            length_q <= '0;
            ecnt_q   <= '0;
            sel_q    <= '0;
        end else begin
            if (accept) vec_q <= up_dat;
            cnt_q    <= cnt_d;
            length_q <= length_d;
            ecnt_q   <= ecnt_d;
            sel_q    <= sel_d;
        end
    end

endmodule

// File: tb/tb_butterfly_p2s.sv
// Bench for butterfly_p2s: directed table and corner sequences plus random traffic against a frame-level model.
module tb_butterfly_p2s;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 8;

    logic            clk;
    logic            rst_n;
    logic [N*DW-1:0] up_dat;
    logic            up_vld;
    logic            up_rdy;
    logic [15:0]     length;
    logic [DW-1:0]   dn_dat;
    logic            dn_vld;
    logic            dn_rdy;

    butterfly_p2s #(.data_width(DW), .num_input(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .up_dat (up_dat),
        .up_vld (up_vld),
        .up_rdy (up_rdy),
        .length (length),
        .dn_dat (dn_dat),
        .dn_vld (dn_vld),
        .dn_rdy (dn_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: pending output elements, frame position and frame length.
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] seen  [$];
    int unsigned   fc;
    int unsigned   fl;

    typedef struct {
        logic        vld;
        logic        rdy;
        logic        exp_vld;
        logic [15:0] exp_dat;
        logic        exp_rdy;
    } vec_t;

    vec_t        tbl [18];
    int          dat_seq [18] = '{0,0,1,2,3,4,5,6,7,1,2,3,4,5,6,7,0,0};
    logic [17:0] vld_seq      = 18'b000000000111111111;
    logic [17:0] ev_seq       = 18'b011111111111111110;
    logic [17:0] er_seq       = 18'b110000000100000001;
    int          exp_v3 [8]   = '{2,3,4,5,6,7,0,1};
    int          exp_l12 [20] = '{0,1,2,3,4,5,6,7,1,2,3,4,0,1,2,3,4,5,6,7};

    logic [N*DW-1:0] ramp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Element at frame position c comes from lane (c mod N + popcount((c div N) mod 256)) mod N.
    task automatic model_accept(input logic [N*DW-1:0] v, input logic [15:0] len);
        int unsigned     k, c, lane;
        logic [N*DW-1:0] tmp;
        if (fc == 0) fl = (len == 16'd0) ? 65536 : int'(len);
        k = (fl - fc < N) ? fl - fc : N;
        for (int unsigned j = 0; j < k; j++) begin
            c    = fc + j;
            lane = ((c % N) + $countones((c / N) % 256)) % N;
            tmp  = v >> (lane * DW);
            exp_q.push_back(tmp[DW-1:0]);
        end
        fc = (fc + k) % fl;
    endtask

    task automatic step(input logic vld, input logic [N*DW-1:0] dat, input logic rdy,
                        input logic [15:0] len, output logic acc);
        logic model_rdy;
        @(negedge clk);
        up_vld = vld;
        up_dat = dat;
        dn_rdy = rdy;
        length = len;
        #1;
        model_rdy = (exp_q.size() == 0) || (rdy && exp_q.size() == 1);
        check("dn_vld", 32'(dn_vld), 32'(exp_q.size() != 0));
        check("up_rdy", 32'(up_rdy), 32'(model_rdy));
        if (exp_q.size() != 0) check("dn_dat", 32'(dn_dat), 32'(exp_q[0]));
        else                   check("dn_dat_idle", 32'(dn_dat), 32'd0);
        if (exp_q.size() != 0 && rdy) begin
            seen.push_back(dn_dat);
            void'(exp_q.pop_front());
        end
        acc = vld && model_rdy;
        if (acc) model_accept(dat, len);
    endtask

    task automatic run_vectors(input int n, input logic [15:0] len, input logic [N*DW-1:0] v);
        int   acc_cnt;
        int   budget;
        logic a;
        acc_cnt = 0;
        budget  = 0;
        while ((acc_cnt < n || exp_q.size() != 0) && budget < 1000) begin
            step(acc_cnt < n, v, 1'b1, len, a);
            if (a) acc_cnt++;
            budget++;
        end
        check("run_timeout", 32'(budget < 1000), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        up_vld = 1'b0;
        dn_rdy = 1'b0;
        #1;
        check("rst_dn_vld", 32'(dn_vld), 32'd0);
        check("rst_up_rdy", 32'(up_rdy), 32'd1);
        check("rst_dn_dat", 32'(dn_dat), 32'd0);
        exp_q.delete();
        seen.delete();
        fc = 0;
        fl = 65536;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic a;
        rst_n  = 1'b0;
        up_vld = 1'b0;
        up_dat = '0;
        dn_rdy = 1'b0;
        length = 16'd16;
        ramp   = '0;
        for (int i = 0; i < int'(N); i++) ramp = ramp | ((N*DW)'(i) << (i * int'(DW)));
        for (int i = 0; i < 18; i++) begin
            tbl[i].vld     = vld_seq[i];
            tbl[i].rdy     = 1'b1;
            tbl[i].exp_vld = ev_seq[i];
            tbl[i].exp_dat = 16'(dat_seq[i]);
            tbl[i].exp_rdy = er_seq[i];
        end
        do_reset();

        // length 16, two ramp vectors, continuous downstream ready
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].vld, ramp, tbl[i].rdy, 16'd16, a);
            check("tbl_vld", 32'(dn_vld), 32'(tbl[i].exp_vld));
            check("tbl_dat", 32'(dn_dat), 32'(tbl[i].exp_dat));
            check("tbl_rdy", 32'(up_rdy), 32'(tbl[i].exp_rdy));
        end

        // length 32: fourth vector rotated by popcount 2, next frame restarts at lane 0
        do_reset();
        run_vectors(4, 16'd32, ramp);
        run_vectors(1, 16'd32, ramp);
        check("l32_count", 32'(seen.size()), 32'd40);
        if (seen.size() == 40) begin
            for (int i = 0; i < 8; i++) check("l32_vec3", 32'(seen[24+i]), 32'(exp_v3[i]));
            check("l32_restart", 32'(seen[32]), 32'd0);
        end

        // backpressure holding lane 2
        do_reset();
        step(1'b1, ramp, 1'b1, 16'd16, a);
        step(1'b0, ramp, 1'b1, 16'd16, a);
        step(1'b0, ramp, 1'b1, 16'd16, a);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ramp, 1'b0, 16'd16, a);
            check("bp_dat", 32'(dn_dat), 32'h2);
            check("bp_vld", 32'(dn_vld), 32'd1);
            check("bp_rdy", 32'(up_rdy), 32'd0);
        end
        step(1'b0, ramp, 1'b1, 16'd16, a);
        step(1'b0, ramp, 1'b1, 16'd16, a);
        check("bp_resume", 32'(dn_dat), 32'h3);
        run_vectors(0, 16'd16, ramp);
        check("bp_count", 32'(seen.size()), 32'd8);

        // length 12: second vector truncated after four lanes
        do_reset();
        run_vectors(3, 16'd12, ramp);
        check("l12_count", 32'(seen.size()), 32'd20);
        if (seen.size() == 20)
            for (int i = 0; i < 20; i++) check("l12_seq", 32'(seen[i]), 32'(exp_l12[i]));

        // reset after the fifth element
        do_reset();
        step(1'b1, ramp, 1'b1, 16'd16, a);
        while (seen.size() < 5 && total < 100000) step(1'b0, ramp, 1'b1, 16'd16, a);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(dn_vld), 32'd0);
        check("mid_rst_rdy", 32'(up_rdy), 32'd1);
        exp_q.delete();
        seen.delete();
        fc = 0;
        fl = 65536;
        @(negedge clk);
        rst_n = 1'b1;
        run_vectors(1, 16'd16, ramp);
        check("mid_rst_count", 32'(seen.size()), 32'd8);
        if (seen.size() == 8)
            for (int i = 0; i < 8; i++) check("mid_rst_seq", 32'(seen[i]), 32'(i));

        // random traffic, short frames
        do_reset();
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 3) != 0, 16'($urandom_range(1, 40)), a);
        run_vectors(0, 16'd8, ramp);

        // random traffic, length 0 (65536) so the popcount field sweeps wide
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) != 0, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 7) != 0, 16'd0, a);
        run_vectors(0, 16'd0, ramp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
